// File: rtl/capi_mmio_pkg.sv
// rtl/capi_mmio_pkg.sv - shared types, constants and helpers for the CAPI MMIO controller
//
// Purpose : FSM state encoding, default timeout, read-error data pattern and the
//           odd-parity helper used on the ah_mmdata return path.
// Ports   : none (package)
package capi_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CFG  = 2'd2,
    RESP = 2'd3
  } mmio_state_e;

  localparam int          DEF_TIMEOUT = 255;
  localparam logic [63:0] RD_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  // Odd parity: result makes the total count of ones (data + parity) odd.
  function automatic logic odd_par(input logic [63:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/capi_mmio_sw_mux.sv
// rtl/capi_mmio_sw_mux.sv - single-word read data steering mux
//
// Purpose : Replicates the addressed 32-bit word onto both halves of the MMIO
//           return bus for single-word reads; doubleword data passes through.
// Ports   : i_data   [0:63] captured read data (big-endian bit numbering)
//           i_dw            1 = doubleword access
//           i_ad_lsb        word address bit 23 (1 selects word [0:31])
//           o_data   [0:63] steered data
module capi_mmio_sw_mux (
  input  logic [0:63] i_data,
  input  logic        i_dw,
  input  logic        i_ad_lsb,
  output logic [0:63] o_data
);

  always_comb begin
    if (i_dw) begin
      o_data = i_data;
    end else if (i_ad_lsb) begin
      o_data = {i_data[0:31], i_data[0:31]};
    end else begin
      o_data = {i_data[32:63], i_data[32:63]};
    end
  end

endmodule

// File: rtl/capi_mmio_ctl.sv
// rtl/capi_mmio_ctl.sv - PSL MMIO request sequencer onto NTGT AFU register targets
//
// Purpose : Captures one MMIO request, decodes the target from the upper address
//           bits, runs a t_val/t_ack handshake with a timeout, steers and parity-
//           protects the read data and pulses ah_mmack.
// Ports   : clk, reset_n                     clock, async active-low reset
//           ha_mm{val,cfg,rnw,dw,ad,data}    PSL MMIO request
//           ah_mm{ack,data,datapar}          registered completion to PSL
//           t_{val,rnw,dw,ad,wdata}          registered target request
//           t_ack, t_rdata                   target completion and read data
//           to_err, prot_err, to_cnt         sticky error flags / timeout count
module capi_mmio_ctl
  import capi_mmio_pkg::*;
#(
  parameter int NTGT    = 4,
  parameter int SELW    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TOW     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ha_mmval,
  input  logic               ha_mmcfg,
  input  logic               ha_mmrnw,
  input  logic               ha_mmdw,
  input  logic [0:23]        ha_mmad,
  input  logic [0:63]        ha_mmdata,
  output logic               ah_mmack,
  output logic [0:63]        ah_mmdata,
  output logic               ah_mmdatapar,
  output logic [0:NTGT-1]    t_val,
  output logic               t_rnw,
  output logic               t_dw,
  output logic [0:23]        t_ad,
  output logic [0:63]        t_wdata,
  input  logic [0:NTGT-1]    t_ack,
  input  logic [0:64*NTGT-1] t_rdata,
  output logic               to_err,
  output logic               prot_err,
  output logic [0:7]         to_cnt
);

  mmio_state_e     r_state;
  mmio_state_e     w_state_nxt;

  logic            r_rnw;
  logic            r_dw;
  logic [0:23]     r_ad;
  logic [0:63]     r_wdata;
  logic [0:NTGT-1] r_t_val;
  logic [TOW-1:0]  r_timer;
  logic            r_ack;
  logic [0:63]     r_ah_data;
  logic            r_ah_par;
  logic            r_to_err;
  logic            r_prot_err;
  logic [7:0]      r_to_cnt;

  logic [SELW-1:0] w_sel;
  logic            w_sel_ack;
  logic            w_timeout;
  logic            w_enter_resp;
  logic [0:NTGT-1] w_onehot;
  logic [0:63]     w_cap;
  logic [0:63]     w_steer;
  logic [0:63]     w_resp_data;

  assign w_sel     = r_ad[0 +: SELW];
  assign w_sel_ack = t_ack[w_sel];
  // An ack in the final REQ cycle takes priority over the timeout.
  assign w_timeout = (r_state == REQ) && !w_sel_ack && (r_timer == TOW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ha_mmval) w_state_nxt = ha_mmcfg ? CFG : REQ;
      REQ:     if (w_sel_ack || w_timeout) w_state_nxt = RESP;
      CFG:     w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output-side combinational values feeding the registered outputs
  always_comb begin
    w_onehot = '0;
    w_onehot[ha_mmad[0 +: SELW]] = 1'b1;
    w_enter_resp = (w_state_nxt == RESP);
    // Config space is unimplemented, so CFG captures zero.
    w_cap = '0;
    if (r_state == REQ) begin
      w_cap = w_sel_ack ? t_rdata[64*w_sel +: 64] : RD_ERR_DATA;
    end
    w_resp_data = r_rnw ? w_steer : '0;
  end

  capi_mmio_sw_mux u_sw_mux (
    .i_data   (w_cap),
    .i_dw     (r_dw),
    .i_ad_lsb (r_ad[23]),
    .o_data   (w_steer)
  );

  // Request capture, target handshake, timer, completion and error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rnw      <= 1'b0;
      r_dw       <= 1'b0;
      r_ad       <= '0;
      r_wdata    <= '0;
      r_t_val    <= '0;
      r_timer    <= '0;
      r_ack      <= 1'b0;
      r_ah_data  <= '0;
      r_ah_par   <= 1'b0;
      r_to_err   <= 1'b0;
      r_prot_err <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_ack <= w_enter_resp;
      if (w_enter_resp) begin
        r_ah_data <= w_resp_data;
        r_ah_par  <= odd_par(w_resp_data);
      end
      if (r_state == IDLE && ha_mmval) begin
        r_rnw   <= ha_mmrnw;
        r_dw    <= ha_mmdw;
        r_ad    <= ha_mmad;
        r_wdata <= ha_mmdata;
        if (!ha_mmcfg) begin
          r_t_val <= w_onehot;
        end
      end
      if (r_state == REQ && (w_sel_ack || w_timeout)) begin
        r_t_val <= '0;
      end
      if (r_state == REQ) begin
        r_timer <= r_timer + TOW'(1);
      end else begin
        r_timer <= '0;
      end
      if (w_timeout) begin
        r_to_err <= 1'b1;
        if (r_to_cnt != 8'hFF) begin
          r_to_cnt <= r_to_cnt + 8'd1;
        end
      end
      if (ha_mmval && r_state != IDLE) begin
        r_prot_err <= 1'b1;
      end
    end
  end

  assign ah_mmack     = r_ack;
  assign ah_mmdata    = r_ah_data;
  assign ah_mmdatapar = r_ah_par;
  assign t_val        = r_t_val;
  assign t_rnw        = r_rnw;
  assign t_dw         = r_dw;
  assign t_ad         = r_ad;
  assign t_wdata      = r_wdata;
  assign to_err       = r_to_err;
  assign prot_err     = r_prot_err;
  assign to_cnt       = r_to_cnt;

endmodule

// File: tb/tb_capi_mmio_ctl.sv
// tb/tb_capi_mmio_ctl.sv - self-checking bench for capi_mmio_ctl
module tb_capi_mmio_ctl;

  localparam int NT = 4;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw;
  logic [0:23]       ha_mmad;
  logic [0:63]       ha_mmdata;
  logic              ah_mmack;
  logic [0:63]       ah_mmdata;
  logic              ah_mmdatapar;
  logic [0:NT-1]     t_val;
  logic              t_rnw, t_dw;
  logic [0:23]       t_ad;
  logic [0:63]       t_wdata;
  logic [0:NT-1]     t_ack;
  logic [0:64*NT-1]  t_rdata;
  logic              to_err, prot_err;
  logic [0:7]        to_cnt;

  int errors = 0;
  int checks = 0;
  int m_to_cnt = 0;
  bit m_to_err = 1'b0;
  bit m_prot = 1'b0;

  typedef struct {
    string       name;
    bit          cfg, rnw, dw;
    logic [23:0] ad;
    logic [63:0] wd, raw, exp_data;
    int          ack_at, exp_ack, exp_tv;
    bit          exp_to;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  capi_mmio_ctl #(.NTGT(NT), .SELW(2), .TIMEOUT(TO), .TOW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ha_mmval(ha_mmval), .ha_mmcfg(ha_mmcfg), .ha_mmrnw(ha_mmrnw), .ha_mmdw(ha_mmdw),
    .ha_mmad(ha_mmad), .ha_mmdata(ha_mmdata),
    .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata), .ah_mmdatapar(ah_mmdatapar),
    .t_val(t_val), .t_rnw(t_rnw), .t_dw(t_dw), .t_ad(t_ad), .t_wdata(t_wdata),
    .t_ack(t_ack), .t_rdata(t_rdata),
    .to_err(to_err), .prot_err(prot_err), .to_cnt(to_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what the PSL should see for a completed access.
  function automatic logic [63:0] ref_data(input bit cfg, input bit rnw, input bit dw,
                                           input logic [23:0] ad, input logic [63:0] raw,
                                           input bit to);
    if (cfg || !rnw) return 64'h0;
    if (to) return 64'hFFFF_FFFF_FFFF_FFFF;
    if (dw) return raw;
    if (ad[0]) return {raw[63:32], raw[63:32]};
    return {raw[31:0], raw[31:0]};
  endfunction

  // Issues one request in cycle 0, plays target (ack in REQ cycle ack_at, 0 = never),
  // injects noise acks on other targets and an optional stray ha_mmval, then checks.
  task automatic run_txn(input string name, input bit cfg, input bit rnw, input bit dw,
                         input logic [23:0] ad, input logic [63:0] wd, input logic [63:0] raw,
                         input int ack_at, input int stray_at, input logic [63:0] exp_data,
                         input int exp_ack, input int exp_tv, input bit exp_to);
    logic [1:0]  sel;
    logic [0:3]  oh;
    logic [63:0] tgt [4];
    logic [63:0] got_data;
    logic        got_par;
    int          tv_cnt, ack_cyc;
    bit          tv_bad, fld_bad;
    sel = ad[23:22];
    oh = '0;
    oh[sel] = 1'b1;
    for (int i = 0; i < 4; i++) tgt[i] = {$urandom, $urandom};
    tgt[sel] = raw;
    tv_cnt = 0; ack_cyc = -1; tv_bad = 1'b0; fld_bad = 1'b0;
    got_data = '0; got_par = 1'b0;
    @(posedge clk); #1;
    ha_mmval = 1'b1; ha_mmcfg = cfg; ha_mmrnw = rnw; ha_mmdw = dw;
    ha_mmad = ad; ha_mmdata = wd;
    t_rdata = {tgt[0], tgt[1], tgt[2], tgt[3]};
    t_ack = '0;
    for (int cyc = 1; cyc <= TO + 20 && ack_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      ha_mmval  = (cyc == stray_at);
      ha_mmad   = (cyc == stray_at) ? ~ad : ad;
      ha_mmdata = (cyc == stray_at) ? ~wd : wd;
      t_ack = 4'($urandom);
      t_ack[sel] = !cfg && (cyc == ack_at);
      @(negedge clk);
      if (t_val !== 4'b0) begin
        tv_cnt++;
        if (t_val !== oh) tv_bad = 1'b1;
        if (t_ad !== ad || t_wdata !== wd || t_rnw !== rnw || t_dw !== dw) fld_bad = 1'b1;
      end
      if (ah_mmack === 1'b1) begin
        ack_cyc = cyc;
        got_data = ah_mmdata;
        got_par = ah_mmdatapar;
      end
    end
    t_ack = '0;
    if (exp_to) begin
      m_to_err = 1'b1;
      if (m_to_cnt < 255) m_to_cnt++;
    end
    // A stray in the ack cycle is sampled at the following edge.
    if (stray_at > 0 && stray_at < exp_ack) m_prot = 1'b1;
    chk({name, " ack_cycle"}, 64'(ack_cyc), 64'(exp_ack));
    chk({name, " data"}, got_data, exp_data);
    chk({name, " parity"}, 64'(got_par), 64'(~^exp_data));
    chk({name, " tval_cycles"}, 64'(tv_cnt), 64'(exp_tv));
    chk({name, " tval_onehot_bad"}, 64'(tv_bad), 64'(0));
    chk({name, " fields_unstable"}, 64'(fld_bad), 64'(0));
    chk({name, " to_err"}, 64'(to_err), 64'(m_to_err));
    chk({name, " to_cnt"}, 64'(to_cnt), 64'(m_to_cnt));
    chk({name, " prot_err"}, 64'(prot_err), 64'(m_prot));
    if (stray_at > 0) m_prot = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " ack_par"}, 64'({ah_mmack, ah_mmdatapar}), 64'(0));
    chk({name, " data"}, 64'(ah_mmdata), 64'(0));
    chk({name, " tval"}, 64'(t_val), 64'(0));
    chk({name, " flags"}, 64'({to_err, prot_err, to_cnt}), 64'(0));
    chk({name, " fields"}, 64'({t_rnw, t_dw, t_ad}), 64'(0));
    chk({name, " wdata"}, 64'(t_wdata), 64'(0));
  endtask

  initial begin
    bit          rs_ack_seen;
    bit          c, r, d, to;
    logic [23:0] a;
    logic [63:0] w, raw, ed;
    int          aa, ea, etv, st;

    vecs[0] = '{"dw_rd_t2", 0, 1, 1, 24'h80_0010, 64'h0, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 1, 2, 1, 0};
    vecs[1] = '{"sw_rd_lo", 0, 1, 0, 24'h40_0020, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                64'hCCCC_DDDD_CCCC_DDDD, 2, 3, 2, 0};
    vecs[2] = '{"sw_rd_hi", 0, 1, 0, 24'hC0_0021, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                64'hAAAA_BBBB_AAAA_BBBB, 1, 2, 1, 0};
    vecs[3] = '{"wr_t1_d5", 0, 0, 1, 24'h40_0100, 64'hDEAD_BEEF_0BAD_F00D,
                64'h5555_6666_7777_8888, 64'h0, 5, 6, 5, 0};
    vecs[4] = '{"cfg_rd", 1, 1, 1, 24'h00_0004, 64'h0, 64'h9999_9999_9999_9999,
                64'h0, 0, 2, 0, 0};
    vecs[5] = '{"timeout", 0, 1, 1, 24'h00_0008, 64'h0, 64'h1234_5678_9ABC_DEF0,
                64'hFFFF_FFFF_FFFF_FFFF, 0, 256, 255, 1};
    vecs[6] = '{"ack_at_to", 0, 1, 0, 24'hC0_0001, 64'h0, 64'h0F0F_1E1E_2D2D_3C3C,
                64'h0F0F_1E1E_0F0F_1E1E, 255, 256, 255, 0};
    vecs[7] = '{"cfg_wr", 1, 0, 0, 24'h00_0010, 64'h1111_2222_3333_4444, 64'h0,
                64'h0, 0, 2, 0, 0};

    reset_n = 1'b0;
    ha_mmval = 1'b0; ha_mmcfg = 1'b0; ha_mmrnw = 1'b0; ha_mmdw = 1'b0;
    ha_mmad = '0; ha_mmdata = '0; t_ack = '0; t_rdata = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].name, vecs[i].cfg, vecs[i].rnw, vecs[i].dw, vecs[i].ad, vecs[i].wd,
              vecs[i].raw, vecs[i].ack_at, 0, vecs[i].exp_data, vecs[i].exp_ack,
              vecs[i].exp_tv, vecs[i].exp_to);
    end

    // Stray request while a transaction is in REQ.
    run_txn("prot_req", 0, 1, 1, 24'h80_0040, 64'h0, 64'h7777_0000_7777_0000, 4, 2,
            64'h7777_0000_7777_0000, 5, 4, 0);
    // Stray in the ack cycle is dropped; a request the very next cycle is accepted.
    run_txn("b2b_a", 0, 0, 1, 24'h00_0200, 64'hCAFE_F00D_1234_5678, 64'h0, 1, 2,
            64'h0, 2, 1, 0);
    run_txn("b2b_b", 0, 1, 0, 24'hC0_0300, 64'h0, 64'hFEED_0001_BEEF_0002, 2, 0,
            64'hBEEF_0002_BEEF_0002, 3, 2, 0);

    // Reset in the middle of a REQ aborts with no ack.
    @(posedge clk); #1;
    ha_mmval = 1'b1; ha_mmcfg = 1'b0; ha_mmrnw = 1'b1; ha_mmdw = 1'b1;
    ha_mmad = 24'h80_0000; t_ack = '0;
    @(posedge clk); #1;
    ha_mmval = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_tval", 64'(t_val), 64'(4'b0010));
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    t_ack = 4'b0010;
    rs_ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ah_mmack !== 1'b0) rs_ack_seen = 1'b1;
    end
    chk("rst_no_ack", 64'(rs_ack_seen), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    t_ack = '0;
    m_to_cnt = 0; m_to_err = 1'b0; m_prot = 1'b0;
    run_txn("post_rst", 0, 1, 1, 24'h40_0008, 64'h0, 64'h0BAD_CAFE_DEAD_0001, 3, 0,
            64'h0BAD_CAFE_DEAD_0001, 4, 3, 0);

    for (int n = 0; n < 24; n++) begin
      c   = ($urandom_range(0, 7) == 0);
      r   = 1'($urandom);
      d   = 1'($urandom);
      a   = 24'($urandom);
      w   = {$urandom, $urandom};
      raw = {$urandom, $urandom};
      aa  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6));
      to  = !c && (aa == 0);
      ea  = c ? 2 : (to ? TO + 1 : aa + 1);
      etv = c ? 0 : (to ? TO : aa);
      ed  = ref_data(c, r, d, a, raw, to);
      st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ea)) : 0;
      run_txn($sformatf("rnd%0d", n), c, r, d, a, w, raw, aa, st, ed, ea, etv, to);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          ha_mmval = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
